clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised successor to the fixed-ratio clock-manager wrapper.
- Generates NUM_CH independent clock-enable strobes, plus matching 180-degree strobes, from one system clock.
- Divide ratio and phase offset are run-time programmable per channel.
- Owns a lock/valid sequencer so downstream logic sees CLK_VALID only once all channels are realigned; sits beside the clock primitive and feeds enable-gated logic in the 50 MHz-class domains.

Parameters:
- NUM_CH, 3: number of enable channels (1..8).
- DIV_W, 8: width of divide and phase fields.
- LOCK_CYCLES, 16: cycles CLK_VALID stays low after reset or reconfiguration (>=1).
- DEF_DIV, 2: reset divide ratio for every channel (>=1).

Ports:
- CLK_IN1  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CFG_WE  in  1  one-cycle configuration write strobe.
- CFG_CH  in  3  target channel index.
- CFG_DIV  in  DIV_W  divide ratio; values 0 and 1 both mean 1.
- CFG_PHASE  in  DIV_W  phase offset in cycles.
- CLK_EN  out  NUM_CH  per-channel one-cycle enable strobe.
- CLK_EN_INV  out  NUM_CH  per-channel strobe at half period.
- CLK_VALID  out  1  high when channels are aligned and running.
- CFG_BUSY  out  1  high while state is LOCKING.

Behaviour:
- States: LOCKING, RUN. No other state is reachable.
- Reset (RESET=1 at an edge):
  - all channels div=DEF_DIV, phase=0;
  - state=LOCKING, lock counter=0;
  - CLK_EN=0, CLK_EN_INV=0, CLK_VALID=0, CFG_BUSY=1.
- LOCKING:
  - all channel counters held at 0; CLK_EN, CLK_EN_INV and CLK_VALID are 0;
  - lock counter increments each cycle;
  - after exactly LOCK_CYCLES cycles in LOCKING, the next cycle is RUN cycle 0.
- RUN:
  - RUN cycle 0 is the first cycle with CLK_VALID=1 and CFG_BUSY=0;
  - channel i is asserted at RUN cycle n iff n mod div_i == phase_i;
  - all channels start from the same cycle 0, so the alignment is deterministic.
- CLK_EN_INV for channel i:
  - asserted iff n mod div_i == (phase_i + floor(div_i/2)) mod div_i;
  - forced 0 when div_i < 2.
- Div=1 channel: CLK_EN is high every RUN cycle.
- Phase rule: if CFG_PHASE >= effective div, stored phase = div-1 (clamp).
- All outputs are registered.
- Config write (CFG_WE=1 at cycle t, CFG_CH < NUM_CH):
  - div/phase updated;
  - from t+1: state=LOCKING, lock counter=0, all counters 0, CLK_VALID=0;
  - every channel realigns, not only the written one.
- CFG_CH >= NUM_CH: write ignored; no state change, no relock.
- Write during LOCKING: accepted; lock counter restarts at 0.
- RESET and CFG_WE in the same cycle: RESET wins and the write is dropped.
- Counter wrap: each channel counter runs 0..div_i-1 and then returns to 0; DIV_W-bit arithmetic, no overflow for div up to 2^DIV_W-1.

Optional Feature:
- Macro: CLK_EN_GEN_STATUS_EN.
- Defined:
  - adds output STATUS, 8 bits, sticky, cleared only by RESET;
  - bit0 = a phase clamp occurred;
  - bit1 = a write targeted an invalid CFG_CH;
  - bit2 = a div of 0 or 1 was written;
  - bits 7:3 read 0;
  - bits set in the cycle after the offending write.
- Not defined: no STATUS port and no status registers; all other behaviour is identical.

Test Plan:
- Reset, LOCK_CYCLES=16, DEF_DIV=2 -> CLK_VALID low for 16 cycles after RESET falls, then high; CLK_EN[i] high at RUN cycles 0, 2, 4, ... and CLK_EN_INV[i] high at 1, 3, 5, ... on every channel.
- Write ch1 div=5 phase=3 during RUN -> CLK_VALID drops at t+1 and returns after 16 cycles; CLK_EN[1] at RUN cycles 3, 8, 13; CLK_EN_INV[1] at 0, 5, 10; ch0/ch2 realigned to cycle 0.
- Write ch0 div=4 phase=9 -> stored phase 3, CLK_EN[0] at cycles 3, 7; with macro, STATUS=0x01.
- Write ch2 div=0 -> CLK_EN[2] high every RUN cycle, CLK_EN_INV[2] stays 0; with macro, STATUS bit2=1.
- Write CFG_CH=7 with NUM_CH=3 -> no relock, CLK_VALID stays 1, strobes unchanged; with macro, STATUS bit1=1.
- Second write 5 cycles into LOCKING, then RESET asserted with CFG_WE in the same cycle -> lock counter restarts at the second write; the write coincident with RESET is dropped and all channels return to div=2.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH run-time programmable clock-enable strobes with half-period companions
// and a lock/valid sequencer. Optional sticky STATUS port under CLK_EN_GEN_STATUS_EN.
module clk_en_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2
) (
  input  logic              CLK_IN1,
  input  logic              RESET,
  input  logic              CFG_WE,
  input  logic [2:0]        CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic [DIV_W-1:0]  CFG_PHASE,
  output logic [NUM_CH-1:0] CLK_EN,
  output logic [NUM_CH-1:0] CLK_EN_INV,
  output logic              CLK_VALID,
  output logic              CFG_BUSY
`ifdef CLK_EN_GEN_STATUS_EN
  ,
  output logic [7:0]        STATUS
`endif
);

  localparam int               LW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO   = DIV_W'(2);
  localparam logic [3:0]       NUM_CH_W  = 4'(NUM_CH);

  typedef enum logic {ST_LOCKING = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [LW-1:0]     r_lock, w_lock_nxt;
  logic [DIV_W-1:0]  r_div [NUM_CH];
  logic [DIV_W-1:0]  r_phase [NUM_CH];
  logic [DIV_W-1:0]  r_cnt [NUM_CH];
  logic [DIV_W-1:0]  w_div_nxt [NUM_CH];
  logic [DIV_W-1:0]  w_phase_nxt [NUM_CH];
  logic [DIV_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [DIV_W-1:0]  w_inv_ph [NUM_CH];
  logic [DIV_W:0]    w_sum [NUM_CH];
  logic [NUM_CH-1:0] r_en, r_inv, w_en_nxt, w_inv_nxt;
  logic              r_valid, r_busy, w_valid_nxt, w_busy_nxt, w_run;
  logic              w_ch_ok, w_wr, w_div_small, w_clamp;
  logic [DIV_W-1:0]  w_div_eff, w_ph_eff;

  assign w_ch_ok     = ({1'b0, CFG_CH} < NUM_CH_W);
  assign w_wr        = CFG_WE & w_ch_ok;
  assign w_div_small = (CFG_DIV < DIV_TWO);
  assign w_div_eff   = w_div_small ? DIV_ONE : CFG_DIV;
  assign w_clamp     = (CFG_PHASE >= w_div_eff);
  assign w_ph_eff    = w_clamp ? (w_div_eff - DIV_ONE) : CFG_PHASE;

  // Half-period phase: (phase + div/2) mod div, computed one bit wider to avoid wrap
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i]    = {1'b0, r_phase[i]} + {1'b0, (r_div[i] >> 1)};
      w_inv_ph[i] = (w_sum[i] >= {1'b0, r_div[i]}) ? DIV_W'(w_sum[i] - {1'b0, r_div[i]})
                                                     : w_sum[i][DIV_W-1:0];
    end
  end

  // Next-state, channel counters and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock;
    w_run       = 1'b0;
    w_en_nxt    = '0;
    w_inv_nxt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_div_nxt[i]   = r_div[i];
      w_phase_nxt[i] = r_phase[i];
      w_cnt_nxt[i]   = '0;
    end

    if (w_wr) begin
      // Any accepted write realigns every channel through a fresh lock period
      w_state_nxt = ST_LOCKING;
      w_lock_nxt  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (CFG_CH == 3'(i)) begin
          w_div_nxt[i]   = w_div_eff;
          w_phase_nxt[i] = w_ph_eff;
        end else begin
          w_div_nxt[i]   = r_div[i];
          w_phase_nxt[i] = r_phase[i];
        end
      end
    end else begin
      case (r_state)
        ST_LOCKING: begin
          if (r_lock == LOCK_LAST) begin
            w_state_nxt = ST_RUN;
            w_lock_nxt  = '0;
            w_run       = 1'b1;
          end else begin
            w_lock_nxt  = r_lock + LW'(1);
          end
        end
        ST_RUN:  w_run = 1'b1;
        default: begin
          w_state_nxt = ST_LOCKING;
          w_lock_nxt  = '0;
        end
      endcase

      // r_cnt holds the RUN-cycle index mod div of the cycle being produced
      if (w_run) begin
        for (int i = 0; i < NUM_CH; i++) begin
          w_en_nxt[i]  = (r_cnt[i] == r_phase[i]);
          w_inv_nxt[i] = (r_div[i] >= DIV_TWO) && (r_cnt[i] == w_inv_ph[i]);
          w_cnt_nxt[i] = (r_cnt[i] == (r_div[i] - DIV_ONE)) ? '0 : (r_cnt[i] + DIV_ONE);
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          w_cnt_nxt[i] = '0;
        end
      end
    end

    w_valid_nxt = (w_state_nxt == ST_RUN);
    w_busy_nxt  = (w_state_nxt == ST_LOCKING);
  end

  // State, configuration and output registers
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      r_state <= ST_LOCKING;
      r_lock  <= '0;
      r_en    <= '0;
      r_inv   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= DIV_RST;
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
      r_en    <= w_en_nxt;
      r_inv   <= w_inv_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= w_div_nxt[i];
        r_phase[i] <= w_phase_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  assign CLK_EN     = r_en;
  assign CLK_EN_INV = r_inv;
  assign CLK_VALID  = r_valid;
  assign CFG_BUSY   = r_busy;

`ifdef CLK_EN_GEN_STATUS_EN
  logic [2:0] r_status;

  // Sticky diagnostics: {div<2 written, invalid channel, phase clamped}
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      r_status <= 3'b000;
    end else begin
      r_status <= r_status | {CFG_WE & w_ch_ok & w_div_small,
                              CFG_WE & ~w_ch_ok,
                              CFG_WE & w_ch_ok & w_clamp};
    end
  end

  assign STATUS = {5'b00000, r_status};
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: a behavioural model predicts every cycle's outputs
// into a scoreboard queue, which is popped and compared after each rising edge.
module tb_clk_en_gen;

  localparam int NCH  = 3;
  localparam int LOCK = 16;

  logic       CLK_IN1   = 1'b0;
  logic       RESET     = 1'b1;
  logic       CFG_WE    = 1'b0;
  logic [2:0] CFG_CH    = 3'd0;
  logic [7:0] CFG_DIV   = 8'd0;
  logic [7:0] CFG_PHASE = 8'd0;
  logic [2:0] CLK_EN, CLK_EN_INV;
  logic       CLK_VALID, CFG_BUSY;
`ifdef CLK_EN_GEN_STATUS_EN
  logic [7:0] STATUS;
`endif

  clk_en_gen #(
    .NUM_CH(NCH), .DIV_W(8), .LOCK_CYCLES(LOCK), .DEF_DIV(2)
  ) dut (
    .CLK_IN1(CLK_IN1), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV), .CFG_PHASE(CFG_PHASE), .CLK_EN(CLK_EN),
    .CLK_EN_INV(CLK_EN_INV), .CLK_VALID(CLK_VALID), .CFG_BUSY(CFG_BUSY)
`ifdef CLK_EN_GEN_STATUS_EN
    , .STATUS(STATUS)
`endif
  );

  always #5 CLK_IN1 = ~CLK_IN1;

  typedef struct packed {
    logic [2:0] en;
    logic [2:0] inv;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stat_q[$];
  int         checks   = 0;
  int         failures = 0;

  int         m_div [NCH];
  int         m_phase [NCH];
  bit         m_locking = 1'b1;
  int         m_lockdone = 0;
  int         m_n = 0;
  logic [7:0] m_status = 8'h00;

  function automatic exp_t expect_now();
    exp_t e;
    int   r;
    e = '0;
    if (m_locking) begin
      e.busy = 1'b1;
    end else begin
      e.valid = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        r         = m_n % m_div[i];
        e.en[i]   = (r == m_phase[i]);
        e.inv[i]  = (m_div[i] >= 2) && (r == ((m_phase[i] + m_div[i] / 2) % m_div[i]));
      end
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic we, input int ch, input int dv,
                      input int ph, input string tag);
    exp_t       got, want;
    logic [7:0] s_want;
    int         eff;
    RESET     = rst;
    CFG_WE    = we;
    CFG_CH    = 3'(ch);
    CFG_DIV   = 8'(dv);
    CFG_PHASE = 8'(ph);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i]   = 2;
        m_phase[i] = 0;
      end
      m_locking  = 1'b1;
      m_lockdone = 0;
      m_status   = 8'h00;
    end else if (we && ch < NCH) begin
      eff = (dv < 2) ? 1 : dv;
      if (ph >= eff) m_status[0] = 1'b1;
      if (dv < 2)    m_status[2] = 1'b1;
      m_div[ch]   = eff;
      m_phase[ch] = (ph >= eff) ? eff - 1 : ph;
      m_locking   = 1'b1;
      m_lockdone  = 0;
    end else begin
      if (we) m_status[1] = 1'b1;
      if (m_locking) begin
        m_lockdone++;
        if (m_lockdone == LOCK) begin
          m_locking = 1'b0;
          m_n       = 0;
        end
      end else begin
        m_n++;
      end
    end
    exp_q.push_back(expect_now());
    stat_q.push_back(m_status);

    @(posedge CLK_IN1);
    #1;
    want   = exp_q.pop_front();
    s_want = stat_q.pop_front();
    got    = {CLK_EN, CLK_EN_INV, CLK_VALID, CFG_BUSY};
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s n=%0d: obs en=%b inv=%b valid=%b busy=%b exp en=%b inv=%b valid=%b busy=%b",
             tag, m_n, got.en, got.inv, got.valid, got.busy,
             want.en, want.inv, want.valid, want.busy);
    end
`ifdef CLK_EN_GEN_STATUS_EN
    checks++;
    assert (STATUS === s_want) else begin
      failures++;
      $error("FAIL %s_status: obs=%h exp=%h", tag, STATUS, s_want);
    end
`else
    if (s_want[7:3] != 5'b00000) $display("model status overflow %h", s_want);
`endif
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      step(1'b0, 1'b0, 0, 0, 0, tag);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 0, 0, 0, "reset");
    step(1'b1, 1'b0, 0, 0, 0, "reset_hold");
    idle(LOCK + 10, "boot_run");

    step(1'b0, 1'b1, 1, 5, 3, "wr_ch1_div5_ph3");
    idle(LOCK + 15, "run_ch1");

    step(1'b0, 1'b1, 0, 4, 9, "wr_ch0_clamp");
    idle(LOCK + 10, "run_ch0");

    step(1'b0, 1'b1, 2, 0, 0, "wr_ch2_div0");
    idle(LOCK + 6, "run_ch2");

    step(1'b0, 1'b1, 7, 3, 1, "wr_bad_ch");
    idle(6, "after_bad_ch");

    step(1'b0, 1'b1, 1, 3, 1, "wr_first");
    idle(5, "lock_partial");
    step(1'b0, 1'b1, 0, 6, 2, "wr_second");
    idle(3, "lock_restart");
    step(1'b1, 1'b1, 1, 7, 0, "rst_with_we");
    idle(LOCK + 8, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
